// File: rtl/fft_lane_delay.sv
// Multi-lane I/Q delay line counted in accepted samples, with runtime-loadable
// depth, flush/priming control and a shared circular write pointer.
module fft_lane_delay #(
    parameter  int DATA_WIDTH  = 9,
    parameter  int NUM_LANES   = 16,
    parameter  int MAX_DEPTH   = 16,
    parameter  int RESET_DELAY = 16,
    localparam int DW          = $clog2(MAX_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] din_i [0:NUM_LANES-1],
    input  logic [DATA_WIDTH-1:0] din_q [0:NUM_LANES-1],
    input  logic [DW-1:0]         cfg_delay,
    input  logic                  cfg_load,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] dout_i [0:NUM_LANES-1],
    output logic [DATA_WIDTH-1:0] dout_q [0:NUM_LANES-1],
    output logic                  out_valid,
    output logic [DW-1:0]         cur_delay
);

    localparam int PW = $clog2(MAX_DEPTH);

    logic [DATA_WIDTH-1:0] mem_i [0:NUM_LANES-1][0:MAX_DEPTH-1];
    logic [DATA_WIDTH-1:0] mem_q [0:NUM_LANES-1][0:MAX_DEPTH-1];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DW-1:0]         fill_cnt;
    logic [DW-1:0]         eff_delay;
    logic [DW-1:0]         eff_fill;
    logic [DW-1:0]         fill_next;
    logic                  restart;
    logic                  sample_ok;

    // A sample coinciding with cfg_load/flush is judged against the new delay
    // and an empty fill, so both are resolved combinationally before use.
    // NOTE: every always_comb output gets a default on its first line so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        eff_delay = cur_delay;
        if (cfg_load) begin
            eff_delay = (cfg_delay > DW'(MAX_DEPTH)) ? DW'(MAX_DEPTH) : cfg_delay;
        end
        restart   = cfg_load || flush;
        eff_fill  = restart ? '0 : fill_cnt;
        fill_next = (eff_fill == DW'(MAX_DEPTH)) ? eff_fill : eff_fill + DW'(1);
        sample_ok = (eff_delay == '0) || (eff_fill >= eff_delay);
        // D == MAX_DEPTH aliases onto the write slot: the old entry is read first.
        rd_ptr    = wr_ptr - eff_delay[PW-1:0];
    end

    // NOTE: the sample buffers sit on the async reset because every entry must
    // read back as zero after reset; this is a deliberate exception to keeping
    // storage arrays reset-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            cur_delay <= DW'(RESET_DELAY);
            out_valid <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                dout_i[l] <= '0;
                dout_q[l] <= '0;
                for (int e = 0; e < MAX_DEPTH; e++) begin
                    mem_i[l][e] <= '0;
                    mem_q[l][e] <= '0;
                end
            end
        end else begin
            cur_delay <= eff_delay;
            out_valid <= in_valid && sample_ok;
            if (in_valid) begin
                fill_cnt <= fill_next;
                wr_ptr   <= wr_ptr + PW'(1);
                for (int l = 0; l < NUM_LANES; l++) begin
                    mem_i[l][wr_ptr] <= din_i[l];
                    mem_q[l][wr_ptr] <= din_q[l];
                    dout_i[l] <= (eff_delay == '0) ? din_i[l] : mem_i[l][rd_ptr];
                    dout_q[l] <= (eff_delay == '0) ? din_q[l] : mem_q[l][rd_ptr];
                end
            end else if (restart) begin
                fill_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fft_lane_delay.sv
// Self-checking bench for fft_lane_delay: directed scenarios plus random traffic
// compared against a history-indexed model of accepted samples.
module tb_fft_lane_delay;

    localparam int DATA_WIDTH  = 9;
    localparam int NUM_LANES   = 16;
    localparam int MAX_DEPTH   = 16;
    localparam int RESET_DELAY = 16;
    localparam int DW          = $clog2(MAX_DEPTH + 1);
    localparam int HIST        = 4096;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] din_i [0:NUM_LANES-1];
    logic [DATA_WIDTH-1:0] din_q [0:NUM_LANES-1];
    logic [DW-1:0]         cfg_delay;
    logic                  cfg_load;
    logic                  flush;
    logic [DATA_WIDTH-1:0] dout_i [0:NUM_LANES-1];
    logic [DATA_WIDTH-1:0] dout_q [0:NUM_LANES-1];
    logic                  out_valid;
    logic [DW-1:0]         cur_delay;

    fft_lane_delay #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (NUM_LANES),
        .MAX_DEPTH  (MAX_DEPTH),
        .RESET_DELAY(RESET_DELAY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .din_i    (din_i),
        .din_q    (din_q),
        .cfg_delay(cfg_delay),
        .cfg_load (cfg_load),
        .flush    (flush),
        .dout_i   (dout_i),
        .dout_q   (dout_q),
        .out_valid(out_valid),
        .cur_delay(cur_delay)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: every accepted sample since reset, indexed by arrival order.
    logic [DATA_WIDTH-1:0] hist_i [0:HIST-1][0:NUM_LANES-1];
    logic [DATA_WIDTH-1:0] hist_q [0:HIST-1][0:NUM_LANES-1];
    logic [DATA_WIDTH-1:0] exp_i  [0:NUM_LANES-1];
    logic [DATA_WIDTH-1:0] exp_q  [0:NUM_LANES-1];
    logic                  exp_valid;
    int                    n_acc;
    int                    m_fill;
    int                    m_delay;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        n_acc     = 0;
        m_fill    = 0;
        m_delay   = RESET_DELAY;
        exp_valid = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            exp_i[l] = '0;
            exp_q[l] = '0;
        end
    endtask

    // Applies the rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int fill_pre;
        int idx;
        if (cfg_load) m_delay = (int'(cfg_delay) > MAX_DEPTH) ? MAX_DEPTH : int'(cfg_delay);
        fill_pre = (cfg_load || flush) ? 0 : m_fill;
        if (in_valid) begin
            exp_valid = (m_delay == 0) || (fill_pre >= m_delay);
            idx = n_acc - m_delay;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (m_delay == 0) begin
                    exp_i[l] = din_i[l];
                    exp_q[l] = din_q[l];
                end else if (idx < 0) begin
                    exp_i[l] = '0;
                    exp_q[l] = '0;
                end else begin
                    exp_i[l] = hist_i[idx][l];
                    exp_q[l] = hist_q[idx][l];
                end
                hist_i[n_acc][l] = din_i[l];
                hist_q[n_acc][l] = din_q[l];
            end
            n_acc  = (n_acc < HIST - 1) ? n_acc + 1 : n_acc;
            m_fill = (fill_pre + 1 > MAX_DEPTH) ? MAX_DEPTH : fill_pre + 1;
        end else begin
            exp_valid = 1'b0;
            m_fill    = fill_pre;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
        chk({tag, ".delay"}, 32'(cur_delay), 32'(m_delay));
        for (int l = 0; l < NUM_LANES; l++) begin
            chk($sformatf("%s.i%0d", tag, l), 32'(dout_i[l]), 32'(exp_i[l]));
            chk($sformatf("%s.q%0d", tag, l), 32'(dout_q[l]), 32'(exp_q[l]));
        end
    endtask

    task automatic set_ramp(input int n);
        for (int l = 0; l < NUM_LANES; l++) begin
            din_i[l] = DATA_WIDTH'(n + l);
            din_q[l] = DATA_WIDTH'(-(n + l));
        end
    endtask

    task automatic set_rand();
        for (int l = 0; l < NUM_LANES; l++) begin
            din_i[l] = DATA_WIDTH'($urandom);
            din_q[l] = DATA_WIDTH'($urandom);
        end
    endtask

    // Called just after an edge; drives inputs, advances one cycle and checks.
    task automatic step(input string tag, input logic v, input logic ld,
                        input int cd, input logic fl);
        in_valid  = v;
        cfg_load  = ld;
        cfg_delay = DW'(cd);
        flush     = fl;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
        cfg_load = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        logic [8:0] pat;
        rst = 1'b1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        flush = 1'b0;
        cfg_delay = '0;
        set_rand();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b0;

        // D=3 ramp: valid first after sample 3, carrying sample n-3.
        step("load3", 1'b0, 1'b1, 3, 1'b0);
        for (int n = 0; n < 12; n++) begin
            set_ramp(n);
            step("d3", 1'b1, 1'b0, 0, 1'b0);
            chk($sformatf("d3.first_valid%0d", n), 32'(out_valid), 32'(n >= 3));
            if (n >= 3) chk($sformatf("d3.ramp%0d", n), 32'(dout_i[5]), 32'(n - 3 + 5));
        end

        // D=4 with gaps: storage advances only on accepted samples.
        step("load4", 1'b0, 1'b1, 4, 1'b0);
        pat = 9'b111001101;
        for (int c = 0; c < 9; c++) begin
            set_rand();
            step("d4gap", pat[c], 1'b0, 0, 1'b0);
        end

        // Bypass loaded together with a sample.
        for (int l = 0; l < NUM_LANES; l++) begin
            din_i[l] = 9'd7;
            din_q[l] = 9'h1f9;
        end
        step("bypass", 1'b1, 1'b1, 0, 1'b0);
        chk("bypass.valid_direct", 32'(out_valid), 32'd1);
        chk("bypass.i_direct", 32'(dout_i[0]), 32'd7);
        chk("bypass.delay_direct", 32'(cur_delay), 32'd0);

        // Oversized request clamps to MAX_DEPTH; run long enough to wrap twice.
        step("load20", 1'b0, 1'b1, 20, 1'b0);
        chk("clamp.delay_direct", 32'(cur_delay), 32'(MAX_DEPTH));
        for (int n = 0; n < 48; n++) begin
            set_ramp(100 + n);
            step("d16", 1'b1, 1'b0, 0, 1'b0);
            if (n >= 16) chk($sformatf("d16.ramp%0d", n), 32'(dout_i[0]), 32'(100 + n - 16));
        end

        // D=2 stream with flush on sample 10.
        step("load2", 1'b0, 1'b1, 2, 1'b0);
        for (int n = 0; n < 14; n++) begin
            set_ramp(n);
            step("d2flush", 1'b1, 1'b0, 0, n == 10);
            if (n >= 10 && n <= 12) chk($sformatf("flush.valid%0d", n), 32'(out_valid), 32'(n == 12));
            if (n == 12) chk("flush.sample10", 32'(dout_i[0]), 32'd10);
        end

        // Random traffic with occasional reconfiguration and flushes.
        for (int c = 0; c < 400; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            set_rand();
            step("rand", 1'($urandom_range(0, 3) != 0), r < 4, int'($urandom_range(0, 20)),
                 (r >= 4 && r < 8) || r == 99);
        end

        // Asynchronous reset mid-stream.
        set_rand();
        in_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            set_rand();
            step("post_rst", 1'b1, 1'b0, 0, 1'b0);
            chk($sformatf("post_rst.valid%0d", n), 32'(out_valid), 32'(n >= RESET_DELAY));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_lane_delay.md
FFT_LANE_DELAY -- requirements
Module: fft_lane_delay

Interface
REQ-001 Parameter DATA_WIDTH, default 9: bit width of each I and Q sample.
REQ-002 Parameter NUM_LANES, default 16: number of parallel I/Q lanes.
REQ-003 Parameter MAX_DEPTH, default 16: maximum delay in accepted samples; power of two, at least 2.
REQ-004 Parameter RESET_DELAY, default 16: delay loaded at reset; range 0..MAX_DEPTH.
REQ-005 Localparam DW = $clog2(MAX_DEPTH+1): width of the delay configuration field.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  din_i/din_q carry a sample this cycle.
REQ-009 din_i  input  DATA_WIDTH x [0:NUM_LANES-1]  in-phase samples.
REQ-010 din_q  input  DATA_WIDTH x [0:NUM_LANES-1]  quadrature samples.
REQ-011 cfg_delay  input  DW  requested delay, sampled when cfg_load=1.
REQ-012 cfg_load  input  1  single-cycle strobe: adopt cfg_delay and restart priming.
REQ-013 flush  input  1  single-cycle strobe: restart priming, keep the current delay.
REQ-014 dout_i  output  DATA_WIDTH x [0:NUM_LANES-1]  delayed in-phase samples, registered.
REQ-015 dout_q  output  DATA_WIDTH x [0:NUM_LANES-1]  delayed quadrature samples, registered.
REQ-016 out_valid  output  1  dout_i/dout_q hold a valid delayed sample this cycle.
REQ-017 cur_delay  output  DW  delay currently in effect.

Function
REQ-018 The delay D counts accepted samples (in_valid=1 cycles), not clock cycles; cycles with in_valid=0 do not advance any storage.
REQ-019 Each lane SHALL keep a MAX_DEPTH-entry circular buffer for I and Q, with a single write pointer shared by all lanes.
REQ-020 On an accepted sample n with D>=1: store din into the buffer, advance the pointer modulo MAX_DEPTH, and drive dout on the next cycle with the lane's sample n-D.
REQ-021 On an accepted sample with D=0 (bypass): dout takes din on the next cycle; out_valid=1 on the next cycle.
REQ-022 fill_cnt counts accepted samples since the last reset, flush or cfg_load, saturating at MAX_DEPTH.
REQ-023 out_valid in cycle t+1 is 1 iff in_valid=1 in cycle t and, for D>=1, fill_cnt before that sample is >= D.
REQ-024 When in_valid=0: out_valid=0 on the next cycle; dout_i/dout_q hold their values.
REQ-025 cfg_load=1: cur_delay <= min(cfg_delay, MAX_DEPTH) and fill_cnt <= 0; buffer contents are retained but treated as stale.
REQ-026 flush=1: fill_cnt <= 0; cur_delay is unchanged.
REQ-027 If cfg_load or flush coincides with in_valid, that sample is written and is the first sample of the new fill, so fill_cnt becomes 1.
REQ-028 For a coinciding sample, its output is evaluated with the new delay and a pre-sample fill of 0: out_valid=1 only if the new D=0.
REQ-029 If cfg_load and flush are asserted together, cfg_load takes precedence; the outcome is identical to cfg_load alone.
REQ-030 Pointer wrap at MAX_DEPTH-1 -> 0 is seamless; D=MAX_DEPTH returns the sample overwritten by the current write (read-before-write).
REQ-031 Lanes are independent in data but share valid, pointer, fill and delay; there is no cross-lane arithmetic and no width change.

Reset
REQ-032 While rst=1: dout_i=0, dout_q=0, out_valid=0, all buffer entries 0, pointer 0, fill_cnt 0, cur_delay=RESET_DELAY.
REQ-033 Reset acts immediately (asynchronous) including mid-stream; the first in_valid after release is sample 0 of a new fill.

Verification
REQ-034 Reset defaults, D=3, lane k input I=n+k, Q=-(n+k), in_valid continuous -> out_valid first high in the cycle after sample 3; it then carries I=n-3+k for sample n.
REQ-035 D=4 with in_valid pattern 1,0,1,1,0,0,1,1,1 -> outputs follow accepted-sample order only; out_valid=0 on every cycle after an in_valid=0 cycle; dout holds during gaps.
REQ-036 cfg_load with cfg_delay=0 in the same cycle as in_valid with I=7 -> next cycle out_valid=1, dout_i=7; cur_delay=0.
REQ-037 cfg_delay=20 with MAX_DEPTH=16 -> cur_delay=16; output equals the sample 16 accepted samples earlier after the pointer wraps at least twice.
REQ-038 D=2 steady stream, flush asserted at sample 10 -> out_valid=0 for samples 10 and 11; valid again at sample 12 with dout = sample 10.
REQ-039 rst pulsed mid-stream -> outputs 0 immediately; after release with D=RESET_DELAY, out_valid stays 0 for the first RESET_DELAY accepted samples.
